// File: rtl/busctrl_tmo.sv
// busctrl_tmo -- CPU-to-slave bus controller with address decode and access
// timeout.
//
// A CPU access is decoded against NSLV base/mask windows. The lowest-index
// window that matches is enabled combinationally, and its wait and read data
// are returned to the CPU. An access that hits nothing is flagged as a miss.
// A slave that holds its wait for TMO_MAX cycles is flagged as a timeout.
// Either error takes the controller through exactly one ERROR cycle, which
// releases the CPU with zero data. The first error is logged in the sticky
// err_* registers.
//
// Ports
//   clk, reset_n      : clock (rising edge), asynchronous active-low reset
//   cpu_en/wr/size    : CPU request, write strobe and access size
//   cpu_addr          : CPU address
//   cpu_data_out      : CPU write data
//   cpu_data_in       : read data returned to the CPU
//   cpu_wt            : CPU wait (1 = access not done)
//   slv_en            : one-hot slave enable, or all zero
//   slv_wr/size/addr  : CPU request fields passed straight through
//   slv_data_in       : CPU write data passed straight through
//   slv_data_out      : flattened slave read data, slave i at [32*i +: 32]
//   slv_wt            : per-slave wait
//   err_irq           : interrupt, equal to err_valid
//   err_valid         : sticky error flag
//   err_cause         : 0 = decode miss, 1 = timeout
//   err_wr, err_addr  : write strobe and address of the logged access
//   err_clr           : synchronous clear of err_valid

// Per-slave address window compare.
module busctrl_tmo_dec #(
    parameter logic [31:0] BASE = 32'h0,
    parameter logic [31:0] MASK = 32'h0
) (
    input  logic [31:0] addr,
    output logic        hit
);
    assign hit = ((addr & MASK) == BASE);
endmodule

module busctrl_tmo #(
    parameter int                 NSLV     = 8,
    parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
    parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'h0}},
    parameter int                 TMO_W    = 8,
    parameter int                 TMO_MAX  = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // CPU side
    input  logic                 cpu_en,
    input  logic                 cpu_wr,
    input  logic [1:0]           cpu_size,
    input  logic [31:0]          cpu_addr,
    input  logic [31:0]          cpu_data_out,
    output logic [31:0]          cpu_data_in,
    output logic                 cpu_wt,
    // slave side
    output logic [NSLV-1:0]      slv_en,
    output logic                 slv_wr,
    output logic [1:0]           slv_size,
    output logic [31:0]          slv_addr,
    output logic [31:0]          slv_data_in,
    input  logic [NSLV*32-1:0]   slv_data_out,
    input  logic [NSLV-1:0]      slv_wt,
    // error log
    output logic                 err_irq,
    output logic                 err_valid,
    output logic                 err_cause,
    output logic                 err_wr,
    output logic [31:0]          err_addr,
    input  logic                 err_clr
);

    typedef enum logic {
        IDLE  = 1'b0,
        ERROR = 1'b1
    } state_t;

    // TMO_MAX must fit in TMO_W bits. The timeout fires while the counter
    // holds TMO_MAX-1, so the CPU sees at most TMO_MAX wait cycles.
    localparam bit               TMO_EN   = (TMO_MAX != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);
    localparam logic [TMO_W-1:0] TCNT_SAT = {TMO_W{1'b1}};

    state_t            state, state_nxt;
    logic [TMO_W-1:0]  tcnt, tcnt_nxt;

    logic [NSLV-1:0]   hit;
    logic [NSLV-1:0]   win;
    logic              any_hit;
    logic [31:0]       sel_data;
    logic              sel_wt;

    logic              err_evt;
    logic              err_cause_nxt;

    // ------------------------------------------------------------------
    // Address decode, one comparator per slave window
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NSLV; gi++) begin : g_dec
            busctrl_tmo_dec #(
                .BASE (SLV_BASE[32*gi +: 32]),
                .MASK (SLV_MASK[32*gi +: 32])
            ) u_dec (
                .addr (cpu_addr),
                .hit  (hit[gi])
            );
        end
    endgenerate

    // Isolate the lowest set bit, so overlapping windows resolve to the
    // lowest index and win is always one-hot or zero.
    assign win     = hit & (~hit + NSLV'(1));
    assign any_hit = |hit;

    // Because win is one-hot, an AND-OR mux is enough for the return path.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NSLV; i++) begin
            sel_data = sel_data | (slv_data_out[32*i +: 32] & {32{win[i]}});
        end
    end

    assign sel_wt = |(win & slv_wt);

    // ------------------------------------------------------------------
    // Pass-through request fields
    // ------------------------------------------------------------------
    assign slv_wr      = cpu_wr;
    assign slv_size    = cpu_size;
    assign slv_addr    = cpu_addr;
    assign slv_data_in = cpu_data_out;

    // ------------------------------------------------------------------
    // FSM next state, CPU-facing outputs, timeout counter next value
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        tcnt_nxt      = '0;
        cpu_wt        = 1'b0;
        cpu_data_in   = '0;
        slv_en        = '0;
        err_evt       = 1'b0;
        err_cause_nxt = 1'b0;

        case (state)
            IDLE: begin
                if (cpu_en) begin
                    if (any_hit) begin
                        slv_en      = win;
                        cpu_wt      = sel_wt;
                        cpu_data_in = sel_data;
                        if (sel_wt) begin
                            if (TMO_EN && (tcnt == TMO_LAST)) begin
                                state_nxt     = ERROR;
                                err_evt       = 1'b1;
                                err_cause_nxt = 1'b1;
                            end else if (TMO_EN && (tcnt != TCNT_SAT)) begin
                                tcnt_nxt = tcnt + TMO_W'(1);
                            end else begin
                                // Saturated, or timeout disabled (tcnt stays 0).
                                tcnt_nxt = tcnt;
                            end
                        end
                    end else begin
                        // Decode miss: hold the CPU for this cycle and let the
                        // ERROR cycle release it.
                        cpu_wt        = 1'b1;
                        state_nxt     = ERROR;
                        err_evt       = 1'b1;
                        err_cause_nxt = 1'b0;
                    end
                end
            end
            ERROR: begin
                // One-cycle release: wait and data stay at their zero defaults.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Sticky error log. The first error is kept until cleared. A clear in
    // the same cycle as a new error re-arms the capture, so the new error
    // is logged.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_valid <= 1'b0;
            err_cause <= 1'b0;
            err_wr    <= 1'b0;
            err_addr  <= '0;
        end else begin
            if (err_evt && (!err_valid || err_clr)) begin
                err_valid <= 1'b1;
                err_cause <= err_cause_nxt;
                err_wr    <= cpu_wr;
                err_addr  <= cpu_addr;
            end else if (err_clr) begin
                err_valid <= 1'b0;
            end
        end
    end

    assign err_irq = err_valid;

endmodule

// File: tb/tb_busctrl_tmo.sv
module tb_busctrl_tmo;

    localparam int TMO_MAX = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_en = 1'b0, cpu_wr = 1'b0;
    logic [1:0]  cpu_size = 2'd0;
    logic [31:0] cpu_addr = '0, cpu_data_out = '0;
    logic [31:0] cpu_data_in;
    logic        cpu_wt;
    logic [1:0]  slv_en;
    logic        slv_wr;
    logic [1:0]  slv_size;
    logic [31:0] slv_addr, slv_data_in;
    logic [63:0] slv_data_out = '0;
    logic [1:0]  slv_wt = '0;
    logic        err_irq, err_valid, err_cause, err_wr;
    logic [31:0] err_addr;
    logic        err_clr = 1'b0;

    int passed = 0;
    int total  = 0;

    busctrl_tmo #(
        .NSLV     (2),
        .SLV_BASE ({32'h3000_0000, 32'h0000_0000}),
        .SLV_MASK ({32'hFFF0_0000, 32'hFE00_0000}),
        .TMO_W    (8),
        .TMO_MAX  (TMO_MAX)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpu_en       (cpu_en),
        .cpu_wr       (cpu_wr),
        .cpu_size     (cpu_size),
        .cpu_addr     (cpu_addr),
        .cpu_data_out (cpu_data_out),
        .cpu_data_in  (cpu_data_in),
        .cpu_wt       (cpu_wt),
        .slv_en       (slv_en),
        .slv_wr       (slv_wr),
        .slv_size     (slv_size),
        .slv_addr     (slv_addr),
        .slv_data_in  (slv_data_in),
        .slv_data_out (slv_data_out),
        .slv_wt       (slv_wt),
        .err_irq      (err_irq),
        .err_valid    (err_valid),
        .err_cause    (err_cause),
        .err_wr       (err_wr),
        .err_addr     (err_addr),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: transaction-level view of the controller
    // ------------------------------------------------------------------
    logic [31:0] m_base [2] = '{32'h0000_0000, 32'h3000_0000};
    logic [31:0] m_mask [2] = '{32'hFE00_0000, 32'hFFF0_0000};
    bit          m_release;      // the next cycle releases a failed access
    int          m_waits;        // wait cycles already spent on this access
    bit          m_lv, m_lcause, m_lwr;
    logic [31:0] m_laddr;
    logic [1:0]  exp_en;
    logic        exp_wt;
    logic [31:0] exp_data;

    function automatic int target_of(logic [31:0] a);
        for (int i = 0; i < 2; i++)
            if ((a & m_mask[i]) == m_base[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_release = 0; m_waits = 0;
        m_lv = 0; m_lcause = 0; m_lwr = 0; m_laddr = '0;
    endtask

    task automatic model_expect();
        int t;
        t = target_of(cpu_addr);
        exp_en = 2'b00; exp_wt = 1'b0; exp_data = 32'h0;
        if (!m_release && cpu_en) begin
            if (t < 0) begin
                exp_wt = 1'b1;
            end else begin
                exp_en   = 2'b01 << t;
                exp_wt   = slv_wt[t];
                exp_data = slv_data_out[32*t +: 32];
            end
        end
    endtask

    task automatic model_step();
        int t;
        bit waiting, new_err, cause;
        t = target_of(cpu_addr);
        waiting = cpu_en && (t >= 0) && slv_wt[t];
        new_err = 0; cause = 0;
        if (!m_release && cpu_en) begin
            if (t < 0) begin
                new_err = 1; cause = 0;
            end else if (waiting && m_waits == TMO_MAX - 1) begin
                new_err = 1; cause = 1;
            end
        end
        if (m_release || !waiting || new_err) m_waits = 0;
        else m_waits++;
        if (new_err && (!m_lv || err_clr)) begin
            m_lv = 1; m_lcause = cause; m_lwr = cpu_wr; m_laddr = cpu_addr;
        end else if (err_clr) begin
            m_lv = 0;
        end
        m_release = new_err;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0: return {7'b0, 25'($urandom)};
            1: return {12'h300, 20'($urandom)};
            2: return 32'($urandom);
            default: return 32'h2000_0000 | 32'($urandom_range(0, 255));
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        #3;
        total++; if (err_valid !== 1'b0) $display("FAIL reset err_valid got %b exp 0", err_valid); else passed++;
        total++; if (err_addr !== 32'h0) $display("FAIL reset err_addr got %h exp 0", err_addr); else passed++;
        total++; if ({err_cause, err_wr, err_irq} !== 3'b000) $display("FAIL reset err_cause/wr/irq got %b exp 000", {err_cause, err_wr, err_irq}); else passed++;
        total++; if ({slv_en, cpu_wt, cpu_data_in} !== 35'h0) $display("FAIL reset idle_out got %h exp 0", {slv_en, cpu_wt, cpu_data_in}); else passed++;
        // Combinational outputs follow IDLE rules while reset is held.
        cpu_en = 1; cpu_addr = 32'h2000_0000;
        #1;
        total++; if (cpu_wt !== 1'b1) $display("FAIL reset miss_wt got %b exp 1", cpu_wt); else passed++;
        cpu_en = 0;
        @(negedge clk);
        reset_n = 1;
        next_cycle();
    endtask

    task automatic test_read_hit();
        cpu_en = 1; cpu_wr = 0; cpu_size = 2'd2; cpu_addr = 32'h0000_0010;
        slv_wt = 2'b00; slv_data_out = {32'hDEAD_BEEF, 32'h1234_5678};
        @(negedge clk);
        total++; if (slv_en !== 2'b01) $display("FAIL rd_hit slv_en got %b exp 01", slv_en); else passed++;
        total++; if (cpu_wt !== 1'b0) $display("FAIL rd_hit cpu_wt got %b exp 0", cpu_wt); else passed++;
        total++; if (cpu_data_in !== 32'h1234_5678) $display("FAIL rd_hit data got %h exp 12345678", cpu_data_in); else passed++;
        total++; if ({slv_addr, slv_wr, slv_size} !== {32'h0000_0010, 1'b0, 2'd2}) $display("FAIL rd_hit passthru got %h", {slv_addr, slv_wr, slv_size}); else passed++;
        next_cycle();
        cpu_addr = 32'h300F_FFF0;
        @(negedge clk);
        total++; if ({slv_en, cpu_data_in} !== {2'b10, 32'hDEAD_BEEF}) $display("FAIL rd_hit1 en/data got %h exp 2deadbeef", {slv_en, cpu_data_in}); else passed++;
        next_cycle();
        cpu_en = 0;
        @(negedge clk);
        total++; if ({err_valid, cpu_data_in} !== 33'h0) $display("FAIL rd_hit idle got %h exp 0", {err_valid, cpu_data_in}); else passed++;
        next_cycle();
    endtask

    task automatic test_timeout();
        cpu_en = 1; cpu_wr = 1; cpu_addr = 32'h3000_0004; cpu_data_out = 32'hA5A5_0001;
        slv_wt = 2'b10; slv_data_out = {32'hCAFE_0000, 32'h0};
        for (int k = 0; k < TMO_MAX; k++) begin
            @(negedge clk);
            total++; if ({cpu_wt, slv_en} !== 3'b110) $display("FAIL tmo_wait%0d wt/en got %b exp 110", k, {cpu_wt, slv_en}); else passed++;
            next_cycle();
        end
        @(negedge clk);
        total++; if ({cpu_wt, slv_en, cpu_data_in} !== 35'h0) $display("FAIL tmo_release got %h exp 0", {cpu_wt, slv_en, cpu_data_in}); else passed++;
        total++; if (slv_data_in !== 32'hA5A5_0001) $display("FAIL tmo slv_data_in got %h exp a5a50001", slv_data_in); else passed++;
        next_cycle();
        cpu_en = 0; slv_wt = 2'b00;
        @(negedge clk);
        total++; if ({err_valid, err_irq, err_cause, err_wr} !== 4'b1111) $display("FAIL tmo_log flags got %b exp 1111", {err_valid, err_irq, err_cause, err_wr}); else passed++;
        total++; if (err_addr !== 32'h3000_0004) $display("FAIL tmo_log addr got %h exp 30000004", err_addr); else passed++;
        next_cycle();
        err_clr = 1;
        next_cycle();
        err_clr = 0;
        @(negedge clk);
        total++; if (err_valid !== 1'b0) $display("FAIL tmo_clr err_valid got %b exp 0", err_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_miss();
        cpu_en = 1; cpu_wr = 0; cpu_addr = 32'h2000_0000;
        @(negedge clk);
        total++; if ({cpu_wt, slv_en} !== 3'b100) $display("FAIL miss_c1 wt/en got %b exp 100", {cpu_wt, slv_en}); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if ({cpu_wt, slv_en, cpu_data_in} !== 35'h0) $display("FAIL miss_c2 got %h exp 0", {cpu_wt, slv_en, cpu_data_in}); else passed++;
        total++; if ({err_valid, err_cause, err_wr} !== 3'b100) $display("FAIL miss_log flags got %b exp 100", {err_valid, err_cause, err_wr}); else passed++;
        total++; if (err_addr !== 32'h2000_0000) $display("FAIL miss_log addr got %h exp 20000000", err_addr); else passed++;
        next_cycle();
        cpu_en = 0; err_clr = 1;
        next_cycle();
        err_clr = 0;
    endtask

    task automatic test_back_to_back();
        cpu_en = 1; cpu_wr = 0; cpu_addr = 32'h2000_0000;
        next_cycle(); next_cycle();
        cpu_addr = 32'h4000_0000; cpu_wr = 1;
        next_cycle();
        @(negedge clk);
        total++; if ({err_valid, err_wr, err_addr} !== {2'b10, 32'h2000_0000}) $display("FAIL b2b_keep got %h exp 2_20000000", {err_valid, err_wr, err_addr}); else passed++;
        next_cycle();
        cpu_addr = 32'h5000_0000; cpu_wr = 0; err_clr = 1;
        @(negedge clk);
        total++; if (err_addr !== 32'h2000_0000) $display("FAIL b2b_preclr addr got %h exp 20000000", err_addr); else passed++;
        next_cycle();
        err_clr = 0; cpu_en = 0;
        @(negedge clk);
        total++; if ({err_valid, err_cause} !== 2'b10) $display("FAIL b2b_set flags got %b exp 10", {err_valid, err_cause}); else passed++;
        total++; if (err_addr !== 32'h5000_0000) $display("FAIL b2b_set addr got %h exp 50000000", err_addr); else passed++;
        next_cycle();
        err_clr = 1;
        next_cycle();
        err_clr = 0;
    endtask

    task automatic test_abandon();
        cpu_en = 1; cpu_wr = 0; cpu_addr = 32'h3000_0010; slv_wt = 2'b10;
        slv_data_out = {32'h0BAD_F00D, 32'h0};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++; if (cpu_wt !== 1'b1) $display("FAIL abandon_wait%0d got %b exp 1", k, cpu_wt); else passed++;
            next_cycle();
        end
        cpu_en = 0;
        @(negedge clk);
        total++; if ({cpu_wt, slv_en, err_valid} !== 4'b0) $display("FAIL abandon_drop got %b exp 0000", {cpu_wt, slv_en, err_valid}); else passed++;
        next_cycle();
        // A fresh count must allow TMO_MAX-1 waits without a timeout.
        cpu_en = 1;
        for (int k = 0; k < TMO_MAX - 1; k++) begin
            @(negedge clk);
            total++; if ({cpu_wt, slv_en} !== 3'b110) $display("FAIL abandon_rewait%0d got %b exp 110", k, {cpu_wt, slv_en}); else passed++;
            next_cycle();
        end
        slv_wt = 2'b00;
        @(negedge clk);
        total++; if ({cpu_wt, slv_en, cpu_data_in} !== {3'b010, 32'h0BAD_F00D}) $display("FAIL abandon_done got %h exp 20badf00d", {cpu_wt, slv_en, cpu_data_in}); else passed++;
        next_cycle();
        cpu_en = 0;
        @(negedge clk);
        total++; if (err_valid !== 1'b0) $display("FAIL abandon_nolog got %b exp 0", err_valid); else passed++;
        next_cycle();
    endtask

    task automatic test_async_reset();
        cpu_en = 1; cpu_wr = 0; cpu_addr = 32'h6000_0000;
        next_cycle();
        // Now in the release cycle of a miss with err_valid set.
        #2 reset_n = 0; #1;
        total++; if ({err_valid, err_addr} !== 33'h0) $display("FAIL arst_err got %h exp 0", {err_valid, err_addr}); else passed++;
        total++; if ({cpu_wt, slv_en} !== 3'b100) $display("FAIL arst_idle got %b exp 100", {cpu_wt, slv_en}); else passed++;
        cpu_en = 0; reset_n = 1;
        next_cycle();
        cpu_en = 1; cpu_wr = 1; cpu_addr = 32'h3000_0100; slv_wt = 2'b10;
        for (int k = 0; k < TMO_MAX - 1; k++) begin
            @(negedge clk);
            total++; if (cpu_wt !== 1'b1) $display("FAIL arst_pre%0d wt got %b exp 1", k, cpu_wt); else passed++;
            next_cycle();
        end
        #1 reset_n = 0; #1;
        total++; if ({err_valid, cpu_wt, slv_en} !== 4'b0110) $display("FAIL arst_midwait got %b exp 0110", {err_valid, cpu_wt, slv_en}); else passed++;
        reset_n = 1;
        // The abandoned access restarts its count from zero.
        for (int k = 0; k < TMO_MAX; k++) begin
            @(negedge clk);
            total++; if (cpu_wt !== 1'b1) $display("FAIL arst_post%0d wt got %b exp 1", k, cpu_wt); else passed++;
            next_cycle();
        end
        @(negedge clk);
        total++; if ({cpu_wt, slv_en} !== 3'b000) $display("FAIL arst_tmo got %b exp 000", {cpu_wt, slv_en}); else passed++;
        next_cycle();
        cpu_en = 0; slv_wt = 2'b00;
        @(negedge clk);
        total++; if ({err_valid, err_cause, err_addr} !== {2'b11, 32'h3000_0100}) $display("FAIL arst_log got %h exp 3_30000100", {err_valid, err_cause, err_addr}); else passed++;
        next_cycle();
        err_clr = 1;
        next_cycle();
        err_clr = 0;
    endtask

    task automatic test_random();
        reset_n = 0; #2; reset_n = 1;
        model_reset();
        for (int c = 0; c < 400; c++) begin
            cpu_en       = ($urandom_range(0, 3) != 0);
            cpu_wr       = 1'($urandom_range(0, 1));
            cpu_size     = 2'($urandom_range(0, 3));
            if (c == 0 || $urandom_range(0, 2) == 0) cpu_addr = rand_addr();
            cpu_data_out = $urandom;
            slv_wt       = {1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7)};
            slv_data_out = {$urandom, $urandom};
            err_clr      = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            model_expect();
            total++; if (slv_en !== exp_en) $display("FAIL rnd%0d slv_en got %b exp %b", c, slv_en, exp_en); else passed++;
            total++; if (cpu_wt !== exp_wt) $display("FAIL rnd%0d cpu_wt got %b exp %b", c, cpu_wt, exp_wt); else passed++;
            total++; if (cpu_data_in !== exp_data) $display("FAIL rnd%0d data got %h exp %h", c, cpu_data_in, exp_data); else passed++;
            total++; if ({err_valid, err_irq} !== {m_lv, m_lv}) $display("FAIL rnd%0d err_valid got %b exp %b", c, err_valid, m_lv); else passed++;
            if (m_lv) begin
                total++; if ({err_cause, err_wr, err_addr} !== {m_lcause, m_lwr, m_laddr}) $display("FAIL rnd%0d err_info got %h exp %h", c, {err_cause, err_wr, err_addr}, {m_lcause, m_lwr, m_laddr}); else passed++;
            end
            total++; if ({slv_wr, slv_size, slv_addr, slv_data_in} !== {cpu_wr, cpu_size, cpu_addr, cpu_data_out}) $display("FAIL rnd%0d passthru got %h", c, {slv_wr, slv_size, slv_addr, slv_data_in}); else passed++;
            model_step();
            next_cycle();
        end
        err_clr = 0; cpu_en = 0;
    endtask

    initial begin
        test_reset();
        test_read_hit();
        test_timeout();
        test_miss();
        test_back_to_back();
        test_abandon();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/busctrl_tmo.md
BUSCTRL_TMO -- requirements
Module: busctrl_tmo

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NSLV, 8, number of slave ports.
- SLV_BASE, {NSLV{32'h0}}, flattened NSLV x 32-bit base addresses; slave i uses bits [32*i+31:32*i].
- SLV_MASK, {NSLV{32'h0}}, flattened NSLV x 32-bit compare masks, same layout.
- TMO_W, 8, timeout counter width.
- TMO_MAX, 255, wait-cycle limit; 0 disables timeout.
REQ-002 Ports (name, direction, width, meaning) SHALL be; clk and reset_n are one clock and an asynchronous, active-low reset:
- clk, in, 1, clock, rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- cpu_en / cpu_wr, in, 1 each, CPU bus request / write.
- cpu_size, in, 2, access size.
- cpu_addr, in, 32, address.
- cpu_data_out, in, 32, write data.
- cpu_data_in, out, 32, read data.
- cpu_wt, out, 1, wait (1 = not done).
- slv_en, out, NSLV, one-hot slave enable.
- slv_wr, out, 1, = cpu_wr.
- slv_size, out, 2, = cpu_size.
- slv_addr, out, 32, = cpu_addr.
- slv_data_in, out, 32, = cpu_data_out.
- slv_data_out, in, NSLV*32, flattened slave read data.
- slv_wt, in, NSLV, slave waits.
- err_irq, out, 1, = err_valid.
- err_valid, out, 1, sticky error flag.
- err_cause, out, 1, 0 = decode miss, 1 = timeout.
- err_wr, out, 1, cpu_wr of the faulting access.
- err_addr, out, 32, address of the faulting access.
- err_clr, in, 1, synchronous clear pulse.

Function
REQ-003 Slave i SHALL hit when (cpu_addr & MASK_i) == BASE_i; on multiple hits the lowest index SHALL win; slv_en SHALL be one-hot or zero.
REQ-004 slv_en[i] SHALL be combinational: cpu_en & win_i & (state == IDLE).
REQ-005 The FSM SHALL have states IDLE and ERROR only; reset state SHALL be IDLE.
REQ-006 In IDLE with a hit:
- cpu_wt SHALL equal slv_wt[win].
- cpu_data_in SHALL equal the selected slave's 32-bit data slice.
REQ-007 In IDLE with no hit, or with cpu_en=0: cpu_data_in SHALL be 32'h0.
REQ-008 Timeout counter tcnt (TMO_W bits) behaviour:
- Increments each cycle in IDLE with cpu_en=1, a hit, and slv_wt[win]=1.
- Clears to 0 when cpu_wt=0, when cpu_en=0, or on entry to ERROR.
- Saturates; it never wraps.
REQ-009 In IDLE with cpu_en=1, a hit, slv_wt[win]=1, TMO_MAX!=0 and tcnt == TMO_MAX-1: the next state SHALL be ERROR (timeout).
- The CPU thus sees at most TMO_MAX wait cycles, then exactly one ERROR cycle.
REQ-010 In IDLE with cpu_en=1 and no hit: cpu_wt SHALL be 1 and the next state SHALL be ERROR (miss).
- Total latency of a miss is 2 cycles.
REQ-011 ERROR SHALL last exactly one cycle with slv_en=0, cpu_wt=0 and cpu_data_in=0, then return to IDLE unconditionally.
REQ-012 If cpu_en drops during a waited access, the state SHALL stay IDLE, tcnt SHALL clear to 0, and no error SHALL be logged.
REQ-013 On each IDLE->ERROR transition with err_valid=0, the block SHALL capture err_addr=cpu_addr, err_wr=cpu_wr and err_cause, and set err_valid=1.
- While err_valid=1, later errors SHALL NOT overwrite the captured info.
REQ-014 err_clr SHALL clear err_valid on the next edge; if a new error occurs in the same cycle, the capture (set) SHALL win.
REQ-015 With TMO_MAX=0, waited accesses SHALL never time out and tcnt SHALL stay 0.

Reset
REQ-016 While reset_n=0, the block SHALL asynchronously force state=IDLE, tcnt=0, err_valid=0, err_cause=0, err_wr=0 and err_addr=0.
REQ-017 Combinational outputs SHALL follow the IDLE rules during reset.
REQ-018 An access in progress at reset assertion SHALL be abandoned with no error logged.
REQ-019 The first edge after reset_n rises SHALL be treated as an IDLE cycle.

Verification
Bench parameters: NSLV=2, BASE0=0x00000000/MASK0=0xFE000000, BASE1=0x30000000/MASK1=0xFFF00000, TMO_MAX=4.
REQ-020 Read of 0x00000010 with slave-0 slv_wt=0 and data 0x12345678 -> slv_en=2'b01, cpu_wt=0 and cpu_data_in=0x12345678 in the same cycle; err_valid stays 0.
REQ-021 Write of 0x30000004 with slave-1 slv_wt held at 1 -> cpu_wt=1 for 4 cycles, then one cycle cpu_wt=0 with data 0 -> err_valid=1, err_cause=1, err_wr=1, err_addr=0x30000004.
REQ-022 Read of 0x20000000 (no hit) -> cycle 1 cpu_wt=1 with slv_en=0; cycle 2 cpu_wt=0 with data 0 -> err_cause=0, err_addr=0x20000000.
REQ-023 Two misses back-to-back, then err_clr coincident with a third miss at 0x50000000 -> err_addr keeps the first address until clear; after the coincident cycle err_valid=1 and err_addr=0x50000000.
REQ-024 Slave-1 wait held for 2 cycles, then cpu_en=0 -> no error and tcnt=0; a following access completes normally.
REQ-025 reset_n pulsed low mid-wait -> err_valid=0 and state IDLE immediately, with no clk edge needed.
